// File: rtl/dir_step_ctrl_pkg.sv
// Shared definitions for the direction/step control slice.
// Holds the debounce FSM state encoding and the default timing parameters
// used by dir_step_ctrl and btn_debounce.
package dir_step_ctrl_pkg;

  // Default number of consecutive synchronized samples needed to accept a level change.
  localparam int unsigned DebCyclesDefault = 16;
  // Default clk cycles between step pulses; matches the legacy bit-5 divider rate.
  localparam int unsigned TickDivDefault   = 64;

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StPressWait = 2'b01,
    StHeld      = 2'b10,
    StRelWait   = 2'b11
  } deb_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a debounce FSM.
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   btn    - raw, asynchronous, bouncing button
//   accept - one-cycle press strobe, decoded from registered FSM state and the
//            synchronized button; the parent registers it on the same edge at
//            which the FSM enters StHeld.
import dir_step_ctrl_pkg::*;

module btn_debounce #(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic accept
);

  localparam int unsigned   CntW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            sync_q;
  logic            btn_s;
  deb_state_e      state_q;
  logic [CntW-1:0] cnt_q;

  // Only sync_q ever samples the asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn;
      btn_s  <= sync_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (btn_s) begin
            state_q <= StPressWait;
            cnt_q   <= CntW'(1);
          end
        end
        StPressWait: begin
          if (!btn_s) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StHeld;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHeld: begin
          if (!btn_s) begin
            state_q <= StRelWait;
            cnt_q   <= CntW'(1);
          end
        end
        StRelWait: begin
          if (btn_s) begin
            state_q <= StHeld;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // High exactly in the cycle where StPressWait commits to StHeld.
  assign accept = (state_q == StPressWait) && btn_s && (cnt_q == CntLast);

endmodule

// File: rtl/dir_step_ctrl.sv
// Upstream control stage for the 4-LED rotating sequencer.
// Converts a bouncing button into a toggling direction level and produces a
// one-cycle step strobe at a fixed divided rate (clock-enable style).
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   btn   - raw push-button
//   en    - prescaler run enable; 0 freezes the step generator
//   dir   - direction level (1 = forward), registered
//   step  - one-cycle advance strobe, registered
//   press - one-cycle strobe per accepted press, registered
import dir_step_ctrl_pkg::*;

module dir_step_ctrl #(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault,
  parameter int unsigned TICK_DIV   = TickDivDefault,
  parameter bit          DIR_INIT   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic en,
  output logic dir,
  output logic step,
  output logic press
);

  localparam int unsigned     DivW    = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(TICK_DIV - 1);

  logic            accept;
  logic            dir_q;
  logic            press_q;
  logic            step_q;
  logic [DivW-1:0] div_q;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .accept(accept)
  );

  // dir and press update on the same edge, so a coincident step already sees
  // the new direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q   <= DIR_INIT;
      press_q <= 1'b0;
    end else begin
      press_q <= accept;
      if (accept) begin
        dir_q <= ~dir_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      step_q <= 1'b0;
    end else if (en) begin
      if (div_q == DivLast) begin
        div_q  <= '0;
        step_q <= 1'b1;
      end else begin
        div_q  <= div_q + DivW'(1);
        step_q <= 1'b0;
      end
    end else begin
      step_q <= 1'b0;
    end
  end

  assign dir   = dir_q;
  assign press = press_q;
  assign step  = step_q;

endmodule

// File: tb/tb_dir_step_ctrl.sv
module tb_dir_step_ctrl;

  logic clk;
  logic rst_n;
  logic btn;
  logic en;
  logic dir;
  logic step;
  logic press;

  int errors = 0;
  int checks = 0;

  dir_step_ctrl #(
    .DEB_CYCLES(4),
    .TICK_DIV  (8),
    .DIR_INIT  (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .en   (en),
    .dir  (dir),
    .step (step),
    .press(press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges; returns 1 time unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reset for two edges; the next edge after return is edge 1 after release.
  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [2:0] exp;
    btn   = 1'b0;
    en    = 1'b1;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dir, step, press} !== 3'b100) begin
      errors++;
      $display("FAIL reset_async: {dir,step,press}=%b expected 100", {dir, step, press});
    end
    tick(3);
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      tick(1);
      exp = {1'b1, (i % 8 == 0), 1'b0};
      checks++;
      if ({dir, step, press} !== exp) begin
        errors++;
        $display("FAIL reset_step edge %0d: {dir,step,press}=%b expected %b", i,
                 {dir, step, press}, exp);
      end
    end
  endtask

  // Holds btn high 20 cycles then low 10; press expected at edge 6 only.
  task automatic press_once(input string name, input logic dir_before);
    logic [1:0] exp;
    btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      exp = {(i >= 6) ? ~dir_before : dir_before, (i == 6)};
      checks++;
      if ({dir, press} !== exp) begin
        errors++;
        $display("FAIL %s hold edge %0d: {dir,press}=%b expected %b", name, i, {dir, press}, exp);
      end
    end
    btn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      exp = {~dir_before, 1'b0};
      checks++;
      if ({dir, press} !== exp) begin
        errors++;
        $display("FAIL %s release edge %0d: {dir,press}=%b expected %b", name, i,
                 {dir, press}, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    press_once("clean_press1", 1'b1);
    press_once("clean_press2", 1'b0);
  endtask

  task automatic test_bounce();
    logic [16:0] pat;
    logic [1:0]  exp;
    // Bit i-1 is btn level before edge i: high 3, low 1, high 3, low 10.
    pat = 17'b00000000001110111;
    for (int i = 1; i <= 17; i++) begin
      btn = pat[i-1];
      tick(1);
      checks++;
      if ({dir, press} !== 2'b10) begin
        errors++;
        $display("FAIL bounce_press edge %0d: {dir,press}=%b expected 10", i, {dir, press});
      end
    end
    // Held press is accepted, then the bouncing release must add nothing.
    btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick(1);
      exp = {(i >= 6) ? 1'b0 : 1'b1, (i == 6)};
      checks++;
      if ({dir, press} !== exp) begin
        errors++;
        $display("FAIL bounce_hold edge %0d: {dir,press}=%b expected %b", i, {dir, press}, exp);
      end
    end
    pat = 17'b00000000001000000;
    for (int i = 1; i <= 13; i++) begin
      btn = (i == 3);
      tick(1);
      checks++;
      if ({dir, press} !== 2'b00) begin
        errors++;
        $display("FAIL bounce_release edge %0d: {dir,press}=%b expected 00", i, {dir, press});
      end
    end
    btn = 1'b0;
  endtask

  task automatic test_enable();
    btn = 1'b0;
    en  = 1'b1;
    do_reset();
    tick(5);
    checks++;
    if (step !== 1'b0) begin
      errors++;
      $display("FAIL enable_pre: step=%b expected 0", step);
    end
    en = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      checks++;
      if (step !== 1'b0) begin
        errors++;
        $display("FAIL enable_frozen edge %0d: step=%b expected 0", i, step);
      end
    end
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      checks++;
      if (step !== (i == 3)) begin
        errors++;
        $display("FAIL enable_resume edge %0d: step=%b expected %b", i, step, (i == 3));
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    btn = 1'b0;
    do_reset();
    tick(4);
    btn = 1'b1;
    // Debounce count reaches 2 at edge 4 after the rise.
    tick(4);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dir, press} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_async: {dir,press}=%b expected 10", {dir, press});
    end
    tick(2);
    checks++;
    if ({dir, press} !== 2'b10) begin
      errors++;
      $display("FAIL reset_mid_held: {dir,press}=%b expected 10", {dir, press});
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick(1);
      exp = {(i >= 6) ? 1'b0 : 1'b1, (i == 6)};
      checks++;
      if ({dir, press} !== exp) begin
        errors++;
        $display("FAIL reset_mid edge %0d: {dir,press}=%b expected %b", i, {dir, press}, exp);
      end
    end
    btn = 1'b0;
    tick(10);
  endtask

  task automatic test_coincidence();
    logic [2:0] exp;
    btn = 1'b0;
    en  = 1'b1;
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      if (i == 2) btn = 1'b1;
      // Rise before edge 3 -> press at edge 8, same edge as the first step.
      exp = {(i >= 8) ? 1'b0 : 1'b1, (i == 8), (i == 8)};
      checks++;
      if ({dir, step, press} !== exp) begin
        errors++;
        $display("FAIL coincidence edge %0d: {dir,step,press}=%b expected %b", i,
                 {dir, step, press}, exp);
      end
    end
    btn = 1'b0;
    tick(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_enable();
    test_reset_mid();
    test_coincidence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dir_step_ctrl.md
Name: dir_step_ctrl

Overview:
- Upstream control stage for the 4-LED rotating state machine.
- Turns a raw, bouncing push-button into a clean direction level `dir`: each debounced press toggles it.
- Also produces a one-cycle `step` enable at a fixed divided rate, so the downstream FSM advances on `clk` with `step` instead of using a derived clock.
- Sits between the board button/clock and the LED sequencer.

Parameters:
- DEB_CYCLES, 16, consecutive synchronized samples needed to accept a level change (>=2)
- TICK_DIV, 64, `clk` cycles between `step` pulses (>=2); 64 matches the existing bit-5 divider rate
- DIR_INIT, 1, value of `dir` after reset

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- btn  input  1  raw push-button, asynchronous, bouncing
- en  input  1  prescaler run enable; 0 freezes the step generator
- dir  output  1  direction level to the sequencer (1 = forward)
- step  output  1  one-cycle advance strobe to the sequencer
- press  output  1  one-cycle strobe per accepted press (status/debug)

Behaviour:
- Reset (rst_n=0, async): dir=DIR_INIT, step=0, press=0, synchronizer=0, debounce FSM=IDLE, debounce count=0, prescaler=0. Any debounce in progress is discarded.
- Synchronizer: 2 flip-flops on `btn` give `btn_s`. No other logic samples `btn`.
- Debounce FSM, one step per clk edge, acting on btn_s:
  - IDLE: btn_s=1 -> PRESS_WAIT with count=1; else stay.
  - PRESS_WAIT: btn_s=0 -> IDLE, count=0. btn_s=1 and count=DEB_CYCLES-1 -> HELD, count=0, press=1, dir toggles. Otherwise count+1.
  - HELD: btn_s=0 -> REL_WAIT with count=1; else stay. No repeat while held.
  - REL_WAIT: btn_s=1 -> HELD, count=0. btn_s=0 and count=DEB_CYCLES-1 -> IDLE, count=0. Otherwise count+1. Release produces no pulse.
- Press latency: btn rises with setup met before edge 1. press and the new dir are registered at edge 2+DEB_CYCLES and hold for exactly one cycle (dir holds its new value).
- Count width: $clog2(DEB_CYCLES+1). Count never exceeds DEB_CYCLES-1.
- Prescaler, width $clog2(TICK_DIV):
  - en=1: counts 0..TICK_DIV-1 and wraps to 0.
  - step=1 for the cycle following the edge at which the count wraps. Period exactly TICK_DIV while en=1.
  - en=0: count holds and step=0 on the next edge. On en=1 it resumes from the held value.
- Simultaneous press and step: independent. If both are high in the same cycle, dir already carries the toggled value, so the sequencer steps in the new direction.
- Button held through reset release: FSM starts in IDLE and accepts it as a new press after the normal latency.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package/include (sesion3 defines): debounce state encodings IDLE=2'b00, PRESS_WAIT=2'b01, HELD=2'b10, REL_WAIT=2'b11; default values of DEB_CYCLES and TICK_DIV.
- One sub-module, `btn_debounce`: synchronizer plus FSM, outputs a press pulse.
- dir_step_ctrl instantiates `btn_debounce` and holds the dir toggle register and the prescaler.

Test Plan (DEB_CYCLES=4, TICK_DIV=8, DIR_INIT=1):
- Reset: rst_n=0 for 3 cycles -> dir=1, step=0, press=0 immediately (async). After release -> step high at edges 8, 16, 24 after release, one cycle each.
- Clean press: btn high for 20 cycles -> single press pulse registered at edge 6 after the rise, dir 1->0. Release for 10 cycles, then a second press -> dir 0->1, exactly one pulse per press.
- Bounce: btn pattern high 3, low 1, high 3, low 10 -> press never asserts, dir stays 1. Release bounce (high held, then low 2/high 1/low 10) -> no extra press.
- Enable gating: prescaler at count 5, en=0 for 20 cycles -> no step. en=1 -> next step registered 3 edges later (count 5->6->7->wrap).
- Reset mid-debounce: btn high, rst_n pulsed low at count 2 with btn still high -> no press during reset; press after 6 edges from reset release, dir=0 (toggled from reset value 1).
- Coincidence: align the press so press and step are high in the same cycle -> dir already toggled in that cycle, and press and step both pulse once.
